hexdisplay_sequencer: RTL

Avalon-MM slave controller that sequences the board's 4-digit seven-segment HEX bus (32-bit, one byte per digit). It replaces direct host writes of raw segment patterns with register-driven modes: raw pass-through, hex-nibble decode, timed scrolling of an 8-nibble value across the 4 digits, and blinking. It sits on the PCIe-to-Avalon bridge alongside the other PIO slaves. Its hex_out drives the HEX pins directly.

---
 rtl/hexdisplay_pkg.sv | 23 ++
 rtl/hexdisplay_sequencer_hex7seg_decode.sv | 30 +++
 rtl/hexdisplay_sequencer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/hexdisplay_pkg.sv
// hexdisplay_pkg: shared constants and types for the HEX display sequencer.
// Register addresses, CTRL bit positions and fixed segment patterns.
package hexdisplay_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_VALUE  = 2'd1;
  localparam logic [1:0] ADDR_PERIOD = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int CTRL_DEC    = 0;
  localparam int CTRL_SCROLL = 1;
  localparam int CTRL_BLINK  = 2;

  localparam logic [7:0]  BLANK_PATTERN = 8'h7F;
  localparam logic [31:0] RESET_PATTERN = 32'h4040_4040;

  typedef struct packed {
    logic blink;
    logic scroll;
    logic dec;
  } ctrl_t;

endpackage

// File: rtl/hexdisplay_sequencer_hex7seg_decode.sv
// hex7seg_decode: nibble to active-low seven-segment pattern.
// seg[0]=a .. seg[6]=g.
module hex7seg_decode (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    unique case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
    endcase
  end

endmodule

// File: rtl/hexdisplay_sequencer.sv
// hexdisplay_sequencer: Avalon-MM slave driving a 4-digit HEX bus with
// raw, decoded, scrolling and blinking display modes.
module hexdisplay_sequencer
  import hexdisplay_pkg::*;
#(
  parameter int PERIOD_W   = 26,
  parameter int PERIOD_RST = 25000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [31:0] hex_out
);

  ctrl_t               ctrl;
  logic [31:0]         value;
  logic [PERIOD_W-1:0] period;
  logic [PERIOD_W-1:0] cnt;
  logic [2:0]          pos;
  logic                blank;

  logic wr;
  logic wr_ctrl;
  logic wr_value;
  logic wr_period;
  logic wr_status;
  logic tick;

  assign wr        = chipselect & ~write_n;
  assign wr_ctrl   = wr && (address == ADDR_CTRL);
  assign wr_value  = wr && (address == ADDR_VALUE);
  assign wr_period = wr && (address == ADDR_PERIOD);
  assign wr_status = wr && (address == ADDR_STATUS);

  // A PERIOD write restarts the interval, so it can never tick itself.
  assign tick = ~wr_period && (period != '0) &&
                (cnt == period - PERIOD_W'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl   <= '0;
      value  <= '0;
      period <= PERIOD_W'(PERIOD_RST);
    end else begin
      if (wr_ctrl) begin
        ctrl.dec    <= writedata[CTRL_DEC];
        ctrl.scroll <= writedata[CTRL_SCROLL];
        ctrl.blink  <= writedata[CTRL_BLINK];
      end
      if (wr_value)
        value <= writedata;
      if (wr_period)
        period <= writedata[PERIOD_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      cnt <= '0;
    else if (wr_period || wr_status || period == '0 || tick)
      cnt <= '0;
    else
      cnt <= cnt + PERIOD_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      pos <= '0;
    else if (wr_status)
      pos <= '0;
    else if (tick && ctrl.scroll && ctrl.dec)
      pos <= pos + 3'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      blank <= 1'b0;
    else if (wr_status)
      blank <= 1'b0;
    else if (wr_ctrl && !writedata[CTRL_BLINK])
      blank <= 1'b0;
    else if (tick && ctrl.blink)
      blank <= ~blank;
  end

  logic [3:0][6:0] seg;

  // Digit k shows nibble k, or nibble (pos+k) mod 8 when scrolling.
  for (genvar k = 0; k < 4; k++) begin : g_dig
    logic [2:0] idx;
    assign idx = ctrl.scroll ? pos + 3'(k) : 3'(k);
    hex7seg_decode u_dec (
      .nibble (value[{idx, 2'b00} +: 4]),
      .seg    (seg[k])
    );
  end

  logic [31:0] disp;

  always_comb begin
    disp = value;
    if (blank)
      disp = {4{BLANK_PATTERN}};
    else if (ctrl.dec)
      disp = {1'b0, seg[3], 1'b0, seg[2],
              1'b0, seg[1], 1'b0, seg[0]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      hex_out <= RESET_PATTERN;
    else
      hex_out <= disp;
  end

  always_comb begin
    readdata = '0;
    unique case (address)
      ADDR_CTRL:   readdata = {29'b0, ctrl};
      ADDR_VALUE:  readdata = value;
      ADDR_PERIOD: readdata = 32'(period);
      ADDR_STATUS: readdata = {28'b0, blank, pos};
    endcase
  end

endmodule
